// File: rtl/fetch_queue_if.sv
// fetch_queue_if: fetch -> decode queue bus.
//   master : fetch/decode side (drives in_valid, fetch_instr_pc, flush, dec_ready;
//            observes head entry, stop_fetch, count, overflow)
//   slave  : the queue itself
interface fetch_queue_if #(
  parameter int DEPTH = 4
);
  localparam int CW = $clog2(DEPTH) + 1;

  logic          in_valid;
  logic [63:0]   fetch_instr_pc;  // [63:32] pc, [31:0] instruction
  logic          flush;
  logic          dec_ready;
  logic          dec_valid;
  logic [31:0]   dec_pc;
  logic [31:0]   dec_instr;
  logic          dec_is_ecall;
  logic          stop_fetch;
  logic [CW-1:0] count;
  logic          overflow;

  modport master (
    output in_valid, fetch_instr_pc, flush, dec_ready,
    input  dec_valid, dec_pc, dec_instr, dec_is_ecall, stop_fetch, count, overflow
  );

  modport slave (
    input  in_valid, fetch_instr_pc, flush, dec_ready,
    output dec_valid, dec_pc, dec_instr, dec_is_ecall, stop_fetch, count, overflow
  );
endinterface

// File: rtl/fetch_queue.sv
// fetch_queue: circular buffer of fetched {pc, instruction} pairs feeding decode.
//   clk   : rising-edge clock
//   rst_n : asynchronous active-low reset (clears pointers, count, overflow)
//   q     : fetch_queue_if.slave
//             in_valid/fetch_instr_pc : fetch result to enqueue
//             flush                   : discard everything (redirect)
//             dec_ready               : decode consumes the head
//             dec_valid/dec_pc/dec_instr/dec_is_ecall : head entry
//             stop_fetch              : occupancy reached AFULL_LVL
//             count                   : occupancy
//             overflow                : sticky, an input was dropped when full
// DEPTH must match the DEPTH of the connected interface.
module fetch_queue #(
  parameter int DEPTH     = 4,
  parameter int AFULL_LVL = 3
) (
  input  logic         clk,
  input  logic         rst_n,
  fetch_queue_if.slave q
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [63:0]   mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] cnt;
  logic          ovf;
  logic          empty, full, pop, push, drop;
  logic [63:0]   head;

  assign empty = (cnt == '0);
  assign full  = (cnt == CW'(DEPTH));
  assign pop   = !empty && q.dec_ready && !q.flush;
  // a full queue still takes a new entry when the head leaves in the same cycle
  assign push  = q.in_valid && !q.flush && (!full || pop);
  // flush discards the input for its own reason; only fullness counts as overflow
  assign drop  = q.in_valid && !q.flush && full && !pop;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
      ovf    <= 1'b0;
    end else begin
      if (drop) ovf <= 1'b1;
      if (q.flush) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
        cnt    <= '0;
      end else begin
        if (push) wr_ptr <= wr_ptr + 1'b1;
        if (pop)  rd_ptr <= rd_ptr + 1'b1;
        if (push && !pop)      cnt <= cnt + 1'b1;
        else if (pop && !push) cnt <= cnt - 1'b1;
      end
    end
  end

  // storage is never reset; empty-gating below hides stale contents
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= q.fetch_instr_pc;
  end

  assign head           = empty ? 64'h0 : mem[rd_ptr];
  assign q.dec_valid    = !empty;
  assign q.dec_pc       = head[63:32];
  assign q.dec_instr    = head[31:0];
  assign q.dec_is_ecall = !empty && (head[31:0] == 32'h0000_0073);
  assign q.stop_fetch   = !q.flush && (cnt >= CW'(AFULL_LVL));
  assign q.count        = cnt;
  assign q.overflow     = ovf;
endmodule

// File: tb/tb_fetch_queue.sv
module tb_fetch_queue;
  localparam int DEPTH = 4;
  localparam int AFULL = 3;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  fetch_queue_if #(.DEPTH(DEPTH)) bus ();

  fetch_queue #(.DEPTH(DEPTH), .AFULL_LVL(AFULL)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .q    (bus)
  );

  int n_chk  = 0;
  int n_fail = 0;

  // reference model: plain queue of entries plus sticky overflow flag
  logic [63:0] mq[$];
  bit          movf = 1'b0;
  logic [31:0] out_log[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // model update at each edge from the inputs the DUT sees
  initial begin
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) begin
        mq.delete();
        movf = 1'b0;
      end else if (bus.flush) begin
        mq.delete();
      end else begin
        bit pop_now, full_now;
        full_now = (mq.size() == DEPTH);
        pop_now  = (mq.size() != 0) && bus.dec_ready;
        if (pop_now) void'(mq.pop_front());
        if (bus.in_valid) begin
          if (!full_now || pop_now) mq.push_back(bus.fetch_instr_pc);
          else movf = 1'b1;
        end
      end
    end
  end

  // monitor: compares DUT outputs to the model head every cycle, logs pops
  initial begin
    forever begin
      @(negedge clk);
      check("dec_valid", bus.dec_valid, (mq.size() != 0));
      check("count", bus.count, mq.size());
      check("stop_fetch", bus.stop_fetch, (!bus.flush && mq.size() >= AFULL));
      check("overflow", bus.overflow, movf);
      if (mq.size() != 0) begin
        check("head_pc", bus.dec_pc, mq[0][63:32]);
        check("head_instr", bus.dec_instr, mq[0][31:0]);
        check("ecall", bus.dec_is_ecall, (mq[0][31:0] == 32'h73));
        if (bus.dec_ready && !bus.flush) out_log.push_back(bus.dec_pc);
      end else begin
        check("empty_pc", bus.dec_pc, 0);
        check("empty_instr", bus.dec_instr, 0);
        check("empty_ecall", bus.dec_is_ecall, 0);
      end
    end
  end

  task automatic tick(input int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus.in_valid = 1'b0; bus.flush = 1'b0; bus.dec_ready = 1'b0;
  endtask

  task automatic do_reset();
    idle();
    rst_n = 1'b0;
    #3;
    rst_n = 1'b1;
    tick();
  endtask

  initial begin
    bus.fetch_instr_pc = '0;
    idle();
    #2;
    check("rst_count", bus.count, 0);
    check("rst_valid", bus.dec_valid, 0);
    check("rst_ovf", bus.overflow, 0);
    tick();
    rst_n = 1'b1;
    tick();

    // two pushes, one pop exposing an ecall at the head
    bus.in_valid = 1; bus.fetch_instr_pc = {32'h0, 32'h0050_0093};
    tick();
    bus.fetch_instr_pc = {32'h4, 32'h0000_0073};
    tick();
    bus.in_valid = 0;
    check("t33_count", bus.count, 2);
    check("t33_pc0", bus.dec_pc, 0);
    bus.dec_ready = 1;
    tick();
    bus.dec_ready = 0;
    check("t33_pc1", bus.dec_pc, 32'h4);
    check("t33_ecall", bus.dec_is_ecall, 1);
    check("t33_count1", bus.count, 1);

    // fill to full, then overflow
    do_reset();
    bus.in_valid = 1;
    for (int i = 0; i < 5; i++) begin
      bus.fetch_instr_pc = {32'h10 + 32'(4 * i), 32'h13};
      tick();
      if (i == 2) begin
        check("t34_stop", bus.stop_fetch, 1);
        check("t34_cnt3", bus.count, 3);
      end
      if (i == 3) check("t34_cnt4", bus.count, 4);
    end
    bus.in_valid = 0;
    check("t34_ovf", bus.overflow, 1);
    check("t34_cnt", bus.count, 4);
    check("t34_head", bus.dec_pc, 32'h10);
    // flush must not clear overflow
    bus.flush = 1; tick(); bus.flush = 0;
    check("t34_ovf_flush", bus.overflow, 1);

    // full queue with simultaneous push and pop
    do_reset();
    bus.in_valid = 1;
    for (int i = 0; i < 4; i++) begin
      bus.fetch_instr_pc = {32'h10 + 32'(4 * i), 32'h13};
      tick();
    end
    bus.fetch_instr_pc = {32'h20, 32'h13}; bus.dec_ready = 1;
    tick();
    bus.in_valid = 0;
    check("t35_cnt", bus.count, 4);
    check("t35_head", bus.dec_pc, 32'h14);
    check("t35_ovf", bus.overflow, 0);
    tick(3);
    bus.dec_ready = 0;
    check("t35_tail", bus.dec_pc, 32'h20);
    check("t35_cnt1", bus.count, 1);

    // flush overrides push and pop
    do_reset();
    bus.in_valid = 1;
    for (int i = 0; i < 3; i++) begin
      bus.fetch_instr_pc = {32'(4 * i), 32'h13};
      tick();
    end
    bus.flush = 1; bus.dec_ready = 1; bus.fetch_instr_pc = {32'h40, 32'h13};
    #1;
    check("t36_stop_during", bus.stop_fetch, 0);
    tick();
    idle();
    check("t36_cnt", bus.count, 0);
    check("t36_valid", bus.dec_valid, 0);
    check("t36_stop", bus.stop_fetch, 0);
    check("t36_ovf", bus.overflow, 0);

    // streaming through, pointers wrap several times
    do_reset();
    out_log.delete();
    bus.in_valid = 1; bus.dec_ready = 1;
    for (int i = 0; i < 16; i++) begin
      bus.fetch_instr_pc = {32'(4 * i), 32'h13};
      tick();
      check("t37_cnt_le1", (bus.count <= 1), 1);
    end
    bus.in_valid = 0;
    tick(2);
    bus.dec_ready = 0;
    check("t37_n", out_log.size(), 16);
    for (int i = 0; i < 16 && i < out_log.size(); i++)
      check("t37_order", out_log[i], 32'(4 * i));

    // mid-operation reset
    do_reset();
    bus.in_valid = 1;
    bus.fetch_instr_pc = {32'h8, 32'h13}; tick();
    bus.fetch_instr_pc = {32'hC, 32'h13}; tick();
    bus.in_valid = 0;
    check("t38_cnt2", bus.count, 2);
    rst_n = 1'b0;
    #1;
    check("t38_rcnt", bus.count, 0);
    check("t38_rvalid", bus.dec_valid, 0);
    check("t38_rpc", bus.dec_pc, 0);
    check("t38_rstop", bus.stop_fetch, 0);
    #1;
    rst_n = 1'b1;
    bus.in_valid = 1; bus.fetch_instr_pc = {32'h100, 32'h13};
    tick();
    bus.in_valid = 0;
    check("t38_pc", bus.dec_pc, 32'h100);
    check("t38_cnt", bus.count, 1);

    // randomized traffic; the monitor compares against the model
    do_reset();
    for (int i = 0; i < 600; i++) begin
      bus.in_valid  = ($urandom_range(0, 9) < 7);
      bus.dec_ready = ($urandom_range(0, 9) < 4);
      bus.flush     = ($urandom_range(0, 29) == 0);
      bus.fetch_instr_pc = {$urandom(), ($urandom_range(0, 3) == 0) ? 32'h73 : $urandom()};
      tick();
    end
    idle();
    tick(2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/fetch_queue.md
FETCH_QUEUE -- requirements
Module: fetch_queue

Interface
REQ-001 SHALL have parameter DEPTH, default 4, entry count; power of two, >= 2.
REQ-002 SHALL have parameter AFULL_LVL, default 3, occupancy at which stop_fetch asserts; range 1..DEPTH.
REQ-003 clk  input  1  rising-edge clock.
REQ-004 rst_n  input  1  reset, asynchronous, active-low.
REQ-005 in_valid  input  1  fetch result valid this cycle.
REQ-006 fetch_instr_pc  input  64  bits [63:32] = pc, bits [31:0] = instruction.
REQ-007 flush  input  1  redirect/jump accepted; discard all queued entries.
REQ-008 dec_ready  input  1  decode accepts the head entry this cycle.
REQ-009 dec_valid  output  1  head entry present.
REQ-010 dec_pc  output  32  pc of head entry.
REQ-011 dec_instr  output  32  instruction of head entry.
REQ-012 dec_is_ecall  output  1  head instruction equals 32'h0000_0073 while dec_valid.
REQ-013 stop_fetch  output  1  occupancy >= AFULL_LVL; fetch holds its address.
REQ-014 count  output  $clog2(DEPTH)+1  current occupancy.
REQ-015 overflow  output  1  sticky: a valid input was dropped because the queue was full.

Function
REQ-016 Storage SHALL be DEPTH x 64-bit entries with write pointer wr_ptr and read pointer rd_ptr, each $clog2(DEPTH) bits, wrapping modulo DEPTH.
REQ-017 pop SHALL be dec_valid & dec_ready & !flush.
REQ-018 push SHALL be in_valid & !flush & (count < DEPTH | pop); a simultaneous push and pop on a full queue is accepted.
REQ-019 On push, fetch_instr_pc SHALL be written at wr_ptr and wr_ptr SHALL increment at the same edge.
REQ-020 On pop, rd_ptr SHALL increment at the edge.
REQ-021 count SHALL be +1 on push only, -1 on pop only, and unchanged on both or neither.
REQ-022 dec_valid SHALL equal (count != 0); dec_pc/dec_instr SHALL read the entry at rd_ptr combinationally, and SHALL be 0 when count == 0.
REQ-023 Latency: an entry pushed at edge N SHALL appear on dec_* after edge N when the queue was empty (one cycle, no bypass).
REQ-024 The queue SHALL preserve order; no entry may be duplicated or skipped.
REQ-025 flush SHALL clear wr_ptr, rd_ptr and count at the next edge and SHALL override a push and a pop in the same cycle; dec_valid is 0 in the following cycle.
REQ-026 in_valid while count == DEPTH and no pop SHALL drop the input, leave state unchanged, and set overflow; overflow stays set until reset and is not cleared by flush.
REQ-027 stop_fetch SHALL be combinational from count (count >= AFULL_LVL) and SHALL be 0 during and immediately after flush.
REQ-028 dec_ready while dec_valid == 0 SHALL have no effect.
REQ-029 dec_is_ecall SHALL be 0 whenever dec_valid == 0.

Reset
REQ-030 rst_n low SHALL asynchronously clear wr_ptr, rd_ptr, count and overflow; all outputs read 0 during reset.
REQ-031 Storage contents need no reset; they SHALL NOT be visible while count == 0.
REQ-032 Reset asserted mid-operation SHALL discard all entries; the first push after release appears at the head one cycle later.

Verification
REQ-033 Push {0x0,0x00500093}, then {0x4,0x00000073}, dec_ready=0 -> count=2, dec_pc=0x0; dec_ready=1 for one cycle -> dec_pc=0x4, dec_is_ecall=1, count=1.
REQ-034 Four pushes with dec_ready=0, DEPTH=4 -> stop_fetch=1 after the third push and count=4; a fifth in_valid -> overflow=1, count=4, head unchanged.
REQ-035 Full queue, in_valid=1 and dec_ready=1 in the same cycle -> count stays 4, head advances by one entry, new entry appears at the tail, overflow stays 0.
REQ-036 count=3, flush=1 with in_valid=1 and dec_ready=1 -> next cycle count=0, dec_valid=0, stop_fetch=0; overflow unchanged.
REQ-037 Continuous push at pc 0,4,...,0x3C with dec_ready=1 -> pointers wrap repeatedly, output sequence is exactly 0..0x3C in order, and count never exceeds 1.
REQ-038 rst_n pulsed low with count=2 -> all outputs 0 immediately; after release, push pc=0x100 -> next cycle dec_pc=0x100, count=1.
